// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered result stage behind the ALU. Captures the ALU
//               result and opcode, and keeps the {Z,V,N} condition flags
//               used by branch evaluation, along with a saturating count of
//               flag updates since reset.
//
// Ports       : clk           system clock (rising edge)
//               rst           synchronous active-high reset
//               in_valid      upstream result valid this cycle
//               opcode[3:0]   WISC opcode of the in-flight instruction
//               in_result[15:0] result from the ALU (already saturated)
//               in_ovf        raw signed overflow for ADD/SUB
//               stall         hold the stage contents
//               flush         squash the stage contents (wins over stall)
//               in_ready      stage can accept input (~stall)
//               out_valid     result / op_q are valid
//               result[15:0]  registered ALU result
//               op_q[3:0]     registered opcode
//               flags[2:0]    {Z,V,N} condition flags
//               flag_upd_cnt[7:0] saturating count of flag updates
//
// Options     : ALU_FLAG_BYPASS_EN - when defined, flags shows the next-state
//               flag value combinationally during the cycle an update is
//               being captured; otherwise flags is the flag register only.
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  opcode,
    input  logic [15:0] in_result,
    input  logic        in_ovf,
    input  logic        stall,
    input  logic        flush,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] result,
    output logic [3:0]  op_q,
    output logic [2:0]  flags,
    output logic [7:0]  flag_upd_cnt
);

    localparam logic [3:0] c_op_add = 4'b0000;
    localparam logic [3:0] c_op_sub = 4'b0001;
    localparam logic [3:0] c_op_xor = 4'b0010;
    localparam logic [3:0] c_op_sll = 4'b0100;
    localparam logic [3:0] c_op_sra = 4'b0101;
    localparam logic [3:0] c_op_ror = 4'b0110;
    localparam logic [7:0] c_cnt_max = 8'hFF;

    logic        r_valid;
    logic [15:0] r_result;
    logic [3:0]  r_op;
    logic        r_z;
    logic        r_v;
    logic        r_n;
    logic [7:0]  r_cnt;

    logic        w_capture;
    logic        w_sets_z;
    logic        w_sets_vn;
    logic        w_flag_upd;
    logic        w_z_nxt;
    logic        w_v_nxt;
    logic        w_n_nxt;

    // A capture happens only when neither reset, flush nor stall intervene.
    assign w_capture = ~rst & ~flush & ~stall;

    // ADD/SUB update all three flags; the logical/shift ops only update Z.
    // RED, PADDSB and non-ALU opcodes never touch the flags.
    always_comb begin
        w_sets_z  = 1'b0;
        w_sets_vn = 1'b0;
        case (opcode)
            c_op_add, c_op_sub: begin
                w_sets_z  = 1'b1;
                w_sets_vn = 1'b1;
            end
            c_op_xor, c_op_sll, c_op_sra, c_op_ror: begin
                w_sets_z  = 1'b1;
            end
            default: begin
                w_sets_z  = 1'b0;
                w_sets_vn = 1'b0;
            end
        endcase
    end

    assign w_flag_upd = w_capture & in_valid & w_sets_z;

    // Z is taken from the already-saturated result, so a saturated overflow
    // never reports zero.
    always_comb begin
        w_z_nxt = r_z;
        w_v_nxt = r_v;
        w_n_nxt = r_n;
        if (w_flag_upd) begin
            w_z_nxt = (in_result == 16'h0000);
            if (w_sets_vn) begin
                w_v_nxt = in_ovf;
                w_n_nxt = in_result[15];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= 16'h0000;
            r_op     <= 4'h0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
            r_cnt    <= 8'h00;
        end else if (flush) begin
            // Squash only the valid bit; data and opcode hold, flags untouched.
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid  <= in_valid;
            r_result <= in_result;
            r_op     <= opcode;
            r_z      <= w_z_nxt;
            r_v      <= w_v_nxt;
            r_n      <= w_n_nxt;
            if (w_flag_upd && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign in_ready     = ~stall;
    assign out_valid    = r_valid;
    assign result       = r_result;
    assign op_q         = r_op;
    assign flag_upd_cnt = r_cnt;

`ifdef ALU_FLAG_BYPASS_EN
    // w_*_nxt equals the register value whenever no update is in progress,
    // so this presents the update in the same cycle it is being captured.
    assign flags = {w_z_nxt, w_v_nxt, w_n_nxt};
`else
    assign flags = {r_z, r_v, r_n};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage. Directed scenarios
//               followed by randomized traffic compared against a
//               behavioural model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    localparam logic [3:0] c_add    = 4'd0;
    localparam logic [3:0] c_sub    = 4'd1;
    localparam logic [3:0] c_xor    = 4'd2;
    localparam logic [3:0] c_paddsb = 4'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] in_result = 16'd0;
    logic        in_ovf = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic [3:0]  op_q;
    logic [2:0]  flags;
    logic [7:0]  flag_upd_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit          m_valid;
    logic [15:0] m_result;
    logic [3:0]  m_op;
    logic [2:0]  m_flags;   // {Z,V,N}
    int          m_cnt;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .opcode       (opcode),
        .in_result    (in_result),
        .in_ovf       (in_ovf),
        .stall        (stall),
        .flush        (flush),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .result       (result),
        .op_q         (op_q),
        .flags        (flags),
        .flag_upd_cnt (flag_upd_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit op_sets_z(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) ||
               (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
    endfunction

    function automatic bit op_sets_vn(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1);
    endfunction

    // Flag value after a flag-setting capture of (op,res,ov) from flags f.
    function automatic logic [2:0] flags_after(input logic [2:0] f, input logic [3:0] op,
                                               input logic [15:0] res, input bit ov);
        logic [2:0] n;
        n = f;
        n[2] = (res == 16'd0);
        if (op_sets_vn(op)) begin
            n[1] = ov;
            n[0] = res[15];
        end
        return n;
    endfunction

    // Apply one cycle of inputs, check outputs before the edge, advance model.
    task automatic step(input bit r, input bit iv, input bit s, input bit f,
                        input logic [3:0] op, input logic [15:0] res, input bit ov,
                        input bit do_chk);
        bit         upd;
        logic [2:0] exp_flags;
        rst = r; in_valid = iv; stall = s; flush = f;
        opcode = op; in_result = res; in_ovf = ov;
        #1;
        upd = !r && !f && !s && iv && op_sets_z(op);
        exp_flags = m_flags;
`ifdef ALU_FLAG_BYPASS_EN
        if (upd) exp_flags = flags_after(m_flags, op, res, ov);
`endif
        if (do_chk) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !s});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("result", {16'd0, result}, {16'd0, m_result});
            check("op_q", {28'd0, op_q}, {28'd0, m_op});
            check("flags", {29'd0, flags}, {29'd0, exp_flags});
            check("flag_upd_cnt", {24'd0, flag_upd_cnt}, m_cnt);
        end
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_result = 16'd0; m_op = 4'd0; m_flags = 3'b000; m_cnt = 0;
        end else if (f) begin
            m_valid = 0;
        end else if (!s) begin
            m_valid = iv; m_result = res; m_op = op;
            if (upd) begin
                m_flags = flags_after(m_flags, op, res, ov);
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    // Park inputs so no update is pending, then let combinational paths settle.
    task automatic go_idle();
        rst = 0; in_valid = 0; stall = 0; flush = 0; in_ovf = 0;
        #1;
    endtask

    initial begin
        @(negedge clk);
        // Reset while an ADD is presented: nothing of it survives
        step(1, 1, 0, 0, c_add, 16'h0000, 0, 0);
        step(1, 1, 0, 0, c_add, 16'h0000, 0, 1);
        go_idle();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flags", {29'd0, flags}, 32'd0);
        check("rst_cnt", {24'd0, flag_upd_cnt}, 32'd0);

        // Saturated overflow: Z=0, V=1, N=0
        step(0, 1, 0, 0, c_add, 16'h7FFF, 1, 1);
        go_idle();
        check("ovf_result", {16'd0, result}, 32'h7FFF);
        check("ovf_flags", {29'd0, flags}, 32'b010);
        check("ovf_cnt", {24'd0, flag_upd_cnt}, 32'd1);
        step(0, 1, 0, 0, c_sub, 16'h8000, 1, 1);
        go_idle();
        check("sub_flags", {29'd0, flags}, 32'b011);

        // Z-only op, then a non-flag op
        step(0, 1, 0, 0, c_xor, 16'h0000, 0, 1);
        go_idle();
        check("xor_flags", {29'd0, flags}, 32'b111);
        step(0, 1, 0, 0, c_paddsb, 16'h0000, 0, 1);
        go_idle();
        check("paddsb_flags", {29'd0, flags}, 32'b111);
        check("paddsb_cnt", {24'd0, flag_upd_cnt}, 32'd3);

        // Flush beats stall, stall holds, release captures once
        step(0, 1, 1, 1, c_add, 16'h0000, 0, 1);
        go_idle();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_flags", {29'd0, flags}, 32'b111);
        step(0, 1, 1, 0, c_add, 16'h0000, 0, 1);
        step(0, 1, 0, 0, c_add, 16'h0000, 0, 1);
        step(0, 0, 0, 0, c_add, 16'h0000, 0, 1);
        go_idle();
        check("release_flags", {29'd0, flags}, 32'b100);
        check("release_cnt", {24'd0, flag_upd_cnt}, 32'd4);

        // Flag visibility timing of an ADD 0x8000 capture
        rst = 0; stall = 0; flush = 0; in_valid = 1; opcode = c_add;
        in_result = 16'h8000; in_ovf = 0;
        #1;
`ifdef ALU_FLAG_BYPASS_EN
        check("bypass_same_cycle", {29'd0, flags}, 32'b001);
`else
        check("nobypass_same_cycle", {29'd0, flags}, 32'b100);
`endif
        step(0, 1, 0, 0, c_add, 16'h8000, 0, 1);
        go_idle();
        check("bypass_next_cycle", {29'd0, flags}, 32'b001);

        // Saturation of the update counter
        for (int i = 0; i < 300; i++)
            step(0, 1, 0, 0, c_add, 16'($urandom), 1'($urandom), 1);
        go_idle();
        check("cnt_saturated", {24'd0, flag_upd_cnt}, 32'hFF);

        // First capture immediately after reset
        step(1, 0, 0, 0, c_add, 16'h0000, 0, 1);
        step(0, 1, 0, 0, c_sub, 16'h0000, 0, 1);
        go_idle();
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_cnt", {24'd0, flag_upd_cnt}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit         r, iv, s, f, ov;
            logic [3:0] op;
            logic [15:0] res;
            r   = ($urandom_range(99) < 2);
            iv  = ($urandom_range(99) < 75);
            s   = ($urandom_range(99) < 20);
            f   = ($urandom_range(99) < 10);
            ov  = 1'($urandom);
            op  = 4'($urandom);
            res = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
            step(r, iv, s, f, op, res, ov, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
